// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU control codes, forward-select encodings and datapath defaults
package id_ex_stage_pkg;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_CTL_W   = 5;
  localparam int DEF_RADDR_W = 5;
  localparam int SHAMT_W     = 5;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SLL = 5'b10000;
  localparam logic [4:0] ALU_SRL = 5'b11000;
  localparam logic [4:0] ALU_SRA = 5'b11001;
  localparam logic [4:0] ALU_MUL = 5'b11010;
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_e;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: picks an operand from EX/MEM, MEM/WB or RF data; EX/MEM is the younger producer and wins
module id_ex_stage_fwd_mux import id_ex_stage_pkg::*; #(
  parameter int XLEN    = DEF_XLEN,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic [RADDR_W-1:0] src_i,
  input  logic [XLEN-1:0]    rf_i,
  input  logic               exm_wr_i,
  input  logic [RADDR_W-1:0] exm_dst_i,
  input  logic [XLEN-1:0]    exm_res_i,
  input  logic               mwb_wr_i,
  input  logic [RADDR_W-1:0] mwb_dst_i,
  input  logic [XLEN-1:0]    mwb_res_i,
  output logic [XLEN-1:0]    val_o,
  output fwd_sel_e           sel_o
);
  logic hit_exm, hit_mwb;
  always_comb begin
    hit_exm = (src_i != '0) && exm_wr_i && (exm_dst_i == src_i);
    hit_mwb = (src_i != '0) && mwb_wr_i && (mwb_dst_i == src_i);
    sel_o   = hit_exm ? FWD_EXM : hit_mwb ? FWD_MWB : FWD_RF;
    val_o   = hit_exm ? exm_res_i : hit_mwb ? mwb_res_i : rf_i;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand forwarding, ALU input select and load-use bubbling
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int XLEN    = DEF_XLEN,
  parameter int CTL_W   = DEF_CTL_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               id_valid_i,
  input  logic [XLEN-1:0]    id_pc_i,
  input  logic [RADDR_W-1:0] id_rs_addr_i,
  input  logic [RADDR_W-1:0] id_rt_addr_i,
  input  logic [XLEN-1:0]    id_rs_data_i,
  input  logic [XLEN-1:0]    id_rt_data_i,
  input  logic [XLEN-1:0]    id_imm_i,
  input  logic [SHAMT_W-1:0] id_shamt_i,
  input  logic [CTL_W-1:0]   id_alu_ctl_i,
  input  logic               id_sign_i,
  input  logic               id_alu_src_i,
  input  logic               id_shamt_src_i,
  input  logic               id_reg_write_i,
  input  logic               id_mem_read_i,
  input  logic               id_mem_write_i,
  input  logic [RADDR_W-1:0] id_dst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               exm_reg_write_i,
  input  logic [RADDR_W-1:0] exm_dst_i,
  input  logic [XLEN-1:0]    exm_result_i,
  input  logic               mwb_reg_write_i,
  input  logic [RADDR_W-1:0] mwb_dst_i,
  input  logic [XLEN-1:0]    mwb_result_i,
  output logic               ex_valid_o,
  output logic [XLEN-1:0]    ex_pc_o,
  output logic [XLEN-1:0]    in1_o,
  output logic [XLEN-1:0]    in2_o,
  output logic [CTL_W-1:0]   alu_ctl_o,
  output logic               sign_o,
  output logic [XLEN-1:0]    ex_store_data_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic               ex_mem_write_o,
  output logic [RADDR_W-1:0] ex_dst_o,
  output logic               load_use_stall_o
);
  logic               valid_q, valid_d, sign_q, sign_d, alu_src_q, alu_src_d, shamt_src_q, shamt_src_d;
  logic               reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [XLEN-1:0]    pc_q, pc_d, rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
  logic [RADDR_W-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, dst_q, dst_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [CTL_W-1:0]   alu_ctl_q, alu_ctl_d;
  logic [XLEN-1:0]    fwd_rs, fwd_rt;
  fwd_sel_e           rs_sel, rt_sel;
  logic               bubble, load;
  id_ex_stage_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs (
    .src_i(rs_addr_q), .rf_i(rs_q),
    .exm_wr_i(exm_reg_write_i), .exm_dst_i(exm_dst_i), .exm_res_i(exm_result_i),
    .mwb_wr_i(mwb_reg_write_i), .mwb_dst_i(mwb_dst_i), .mwb_res_i(mwb_result_i),
    .val_o(fwd_rs), .sel_o(rs_sel)
  );
  id_ex_stage_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rt (
    .src_i(rt_addr_q), .rf_i(rt_q),
    .exm_wr_i(exm_reg_write_i), .exm_dst_i(exm_dst_i), .exm_res_i(exm_result_i),
    .mwb_wr_i(mwb_reg_write_i), .mwb_dst_i(mwb_dst_i), .mwb_res_i(mwb_result_i),
    .val_o(fwd_rt), .sel_o(rt_sel)
  );
  always_comb begin
    load_use_stall_o = valid_q && mem_read_q && (dst_q != '0) && id_valid_i &&
                       ((id_rs_addr_i == dst_q) ||
                        ((id_rt_addr_i == dst_q) && (!id_alu_src_i || id_mem_write_i)));
    bubble      = flush_i || (!stall_i && load_use_stall_o);
    load        = !flush_i && !stall_i && !load_use_stall_o;
    valid_d     = bubble ? 1'b0 : load ? id_valid_i     : valid_q;
    pc_d        = bubble ? '0   : load ? id_pc_i        : pc_q;
    rs_addr_d   = bubble ? '0   : load ? id_rs_addr_i   : rs_addr_q;
    rt_addr_d   = bubble ? '0   : load ? id_rt_addr_i   : rt_addr_q;
    rs_d        = bubble ? '0   : load ? id_rs_data_i   : (rs_sel != FWD_RF) ? fwd_rs : rs_q;
    rt_d        = bubble ? '0   : load ? id_rt_data_i   : (rt_sel != FWD_RF) ? fwd_rt : rt_q;
    imm_d       = bubble ? '0   : load ? id_imm_i       : imm_q;
    shamt_d     = bubble ? '0   : load ? id_shamt_i     : shamt_q;
    alu_ctl_d   = bubble ? '0   : load ? id_alu_ctl_i   : alu_ctl_q;
    sign_d      = bubble ? 1'b0 : load ? id_sign_i      : sign_q;
    alu_src_d   = bubble ? 1'b0 : load ? id_alu_src_i   : alu_src_q;
    shamt_src_d = bubble ? 1'b0 : load ? id_shamt_src_i : shamt_src_q;
    reg_write_d = bubble ? 1'b0 : load ? id_reg_write_i : reg_write_q;
    mem_read_d  = bubble ? 1'b0 : load ? id_mem_read_i  : mem_read_q;
    mem_write_d = bubble ? 1'b0 : load ? id_mem_write_i : mem_write_q;
    dst_d       = bubble ? '0   : load ? id_dst_i       : dst_q;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i)
      {valid_q, pc_q, rs_addr_q, rt_addr_q, rs_q, rt_q, imm_q, shamt_q, alu_ctl_q, sign_q,
       alu_src_q, shamt_src_q, reg_write_q, mem_read_q, mem_write_q, dst_q} <= '0;
    else
      {valid_q, pc_q, rs_addr_q, rt_addr_q, rs_q, rt_q, imm_q, shamt_q, alu_ctl_q, sign_q,
       alu_src_q, shamt_src_q, reg_write_q, mem_read_q, mem_write_q, dst_q} <=
      {valid_d, pc_d, rs_addr_d, rt_addr_d, rs_d, rt_d, imm_d, shamt_d, alu_ctl_d, sign_d,
       alu_src_d, shamt_src_d, reg_write_d, mem_read_d, mem_write_d, dst_d};
  assign ex_valid_o      = valid_q;
  assign ex_pc_o         = pc_q;
  assign in1_o           = shamt_src_q ? {{(XLEN-SHAMT_W){1'b0}}, shamt_q} : fwd_rs;
  assign in2_o           = alu_src_q ? imm_q : fwd_rt;
  assign alu_ctl_o       = alu_ctl_q;
  assign sign_o          = sign_q;
  assign ex_store_data_o = fwd_rt;
  assign ex_reg_write_o  = reg_write_q;
  assign ex_mem_read_o   = mem_read_q;
  assign ex_mem_write_o  = mem_write_q;
  assign ex_dst_o        = dst_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, forwarding, load-use bubbling, stall, flush and async reset
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        id_valid_i, id_sign_i, id_alu_src_i, id_shamt_src_i;
  logic        id_reg_write_i, id_mem_read_i, id_mem_write_i, stall_i, flush_i;
  logic [31:0] id_pc_i, id_rs_data_i, id_rt_data_i, id_imm_i, exm_result_i, mwb_result_i;
  logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_shamt_i, id_alu_ctl_i, id_dst_i, exm_dst_i, mwb_dst_i;
  logic        exm_reg_write_i, mwb_reg_write_i;
  logic        ex_valid_o, sign_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, load_use_stall_o;
  logic [31:0] ex_pc_o, in1_o, in2_o, ex_store_data_o;
  logic [4:0]  alu_ctl_o, ex_dst_o;
  int          errors = 0;
  int          checks = 0;
  id_ex_stage dut (
    .clk_i(clk_i), .reset_i(reset_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rs_data_i(id_rs_data_i),
    .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i), .id_shamt_i(id_shamt_i),
    .id_alu_ctl_i(id_alu_ctl_i), .id_sign_i(id_sign_i), .id_alu_src_i(id_alu_src_i),
    .id_shamt_src_i(id_shamt_src_i), .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .id_mem_write_i(id_mem_write_i), .id_dst_i(id_dst_i), .stall_i(stall_i), .flush_i(flush_i),
    .exm_reg_write_i(exm_reg_write_i), .exm_dst_i(exm_dst_i), .exm_result_i(exm_result_i),
    .mwb_reg_write_i(mwb_reg_write_i), .mwb_dst_i(mwb_dst_i), .mwb_result_i(mwb_result_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .in1_o(in1_o), .in2_o(in2_o),
    .alu_ctl_o(alu_ctl_o), .sign_o(sign_o), .ex_store_data_o(ex_store_data_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_dst_o(ex_dst_o), .load_use_stall_o(load_use_stall_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle();
    {id_valid_i, id_sign_i, id_alu_src_i, id_shamt_src_i, id_reg_write_i, id_mem_read_i, id_mem_write_i} = '0;
    {id_pc_i, id_rs_data_i, id_rt_data_i, id_imm_i} = '0;
    {id_rs_addr_i, id_rt_addr_i, id_shamt_i, id_alu_ctl_i, id_dst_i} = '0;
    {stall_i, flush_i} = '0;
    {exm_reg_write_i, mwb_reg_write_i, exm_dst_i, mwb_dst_i, exm_result_i, mwb_result_i} = '0;
  endtask
  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [4:0] ctl, input logic [4:0] dst);
    id_valid_i = 1'b1; id_rs_addr_i = rs; id_rt_addr_i = rt; id_rs_data_i = rsd;
    id_rt_data_i = rtd; id_alu_ctl_i = ctl; id_dst_i = dst; id_reg_write_i = 1'b1;
    {id_alu_src_i, id_shamt_src_i, id_mem_read_i, id_mem_write_i} = '0;
  endtask
  initial begin
    idle();
    #1 reset_i = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'b0, ex_valid_o}, 32'd0);
    chk("rst_in1", in1_o, 32'd0);
    chk("rst_in2", in2_o, 32'd0);
    chk("rst_ctl", {27'b0, alu_ctl_o}, 32'd0);
    chk("rst_lus", {31'b0, load_use_stall_o}, 32'd0);
    reset_i = 1'b0;
    // ADD rs=3 rt=4: RF data first, then forwarded from EX/MEM and MEM/WB
    instr(5'd3, 5'd4, 32'h1, 32'h2, ALU_ADD, 5'd8);
    id_pc_i = 32'h100; id_sign_i = 1'b1;
    tick();
    idle();
    #1;
    chk("add_rf_in1", in1_o, 32'h1);
    chk("add_rf_in2", in2_o, 32'h2);
    chk("add_valid", {31'b0, ex_valid_o}, 32'd1);
    chk("add_pc", ex_pc_o, 32'h100);
    chk("add_ctl", {27'b0, alu_ctl_o}, {27'b0, ALU_ADD});
    chk("add_sign", {31'b0, sign_o}, 32'd1);
    chk("add_dst", {27'b0, ex_dst_o}, 32'd8);
    exm_reg_write_i = 1'b1; exm_dst_i = 5'd3; exm_result_i = 32'h10;
    mwb_reg_write_i = 1'b1; mwb_dst_i = 5'd4; mwb_result_i = 32'h20;
    #1;
    chk("fwd_exm_in1", in1_o, 32'h10);
    chk("fwd_mwb_in2", in2_o, 32'h20);
    // double match on $5: EX/MEM wins, then MEM/WB when EX/MEM stops writing
    instr(5'd5, 5'd0, 32'h11, 32'h0, ALU_OR, 5'd9);
    tick();
    idle();
    exm_reg_write_i = 1'b1; exm_dst_i = 5'd5; exm_result_i = 32'hAAAA;
    mwb_reg_write_i = 1'b1; mwb_dst_i = 5'd5; mwb_result_i = 32'hBBBB;
    #1;
    chk("dbl_exm_wins", in1_o, 32'hAAAA);
    exm_reg_write_i = 1'b0;
    #1;
    chk("dbl_mwb_only", in1_o, 32'hBBBB);
    exm_reg_write_i = 1'b1; exm_dst_i = 5'd0; exm_result_i = 32'hDEAD;
    mwb_dst_i = 5'd0; mwb_result_i = 32'hBEEF;
    #1;
    chk("r0_rt_no_fwd", in2_o, 32'h0);
    instr(5'd0, 5'd0, 32'h0, 32'h0, ALU_ADD, 5'd9);
    tick();
    #1;
    chk("r0_rs_no_fwd", in1_o, 32'h0);
    idle();
    // load-use: LW $7 in EX, ADD reading $7 in ID
    instr(5'd1, 5'd7, 32'h0, 32'h0, ALU_ADD, 5'd7);
    id_alu_src_i = 1'b1; id_imm_i = 32'h4; id_mem_read_i = 1'b1;
    tick();
    instr(5'd6, 5'd7, 32'h0, 32'h0, ALU_ADD, 5'd9);
    id_alu_src_i = 1'b1;
    #1;
    chk("lu_rt_imm_none", {31'b0, load_use_stall_o}, 32'd0);
    id_mem_write_i = 1'b1;
    #1;
    chk("lu_rt_store", {31'b0, load_use_stall_o}, 32'd1);
    instr(5'd7, 5'd2, 32'h99, 32'h5, ALU_ADD, 5'd9);
    #1;
    chk("lu_rs", {31'b0, load_use_stall_o}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'b0, ex_valid_o}, 32'd0);
    chk("lu_bubble_regwr", {31'b0, ex_reg_write_o}, 32'd0);
    chk("lu_bubble_in1", in1_o, 32'h0);
    chk("lu_bubble_ctl", {27'b0, alu_ctl_o}, 32'd0);
    chk("lu_released", {31'b0, load_use_stall_o}, 32'd0);
    tick();
    mwb_reg_write_i = 1'b1; mwb_dst_i = 5'd7; mwb_result_i = 32'hCAFE;
    #1;
    chk("lu_replay_in1", in1_o, 32'hCAFE);
    chk("lu_replay_in2", in2_o, 32'h5);
    chk("lu_replay_dst", {27'b0, ex_dst_o}, 32'd9);
    idle();
    // SLL uses shamt for in1; SW uses imm for in2 but stores forwarded rt
    instr(5'd0, 5'd2, 32'h0, 32'h3, ALU_SLL, 5'd10);
    id_shamt_i = 5'd4; id_shamt_src_i = 1'b1;
    tick();
    idle();
    exm_reg_write_i = 1'b1; exm_dst_i = 5'd2; exm_result_i = 32'h77;
    #1;
    chk("sll_in1", in1_o, 32'h4);
    chk("sll_in2", in2_o, 32'h77);
    instr(5'd1, 5'd2, 32'h1000, 32'h55, ALU_ADD, 5'd0);
    id_reg_write_i = 1'b0; id_alu_src_i = 1'b1; id_imm_i = 32'h8; id_mem_write_i = 1'b1;
    tick();
    idle();
    mwb_reg_write_i = 1'b1; mwb_dst_i = 5'd2; mwb_result_i = 32'h66;
    #1;
    chk("sw_in1", in1_o, 32'h1000);
    chk("sw_in2", in2_o, 32'h8);
    chk("sw_store", ex_store_data_o, 32'h66);
    chk("sw_memwr", {31'b0, ex_mem_write_o}, 32'd1);
    // stall while the $10 producer drains through EX/MEM and MEM/WB
    instr(5'd10, 5'd0, 32'h0, 32'h0, ALU_ADD, 5'd11);
    id_pc_i = 32'h200;
    tick();
    idle();
    instr(5'd3, 5'd3, 32'h9, 32'h9, ALU_SUB, 5'd12);
    id_pc_i = 32'h204; stall_i = 1'b1;
    exm_reg_write_i = 1'b1; exm_dst_i = 5'd10; exm_result_i = 32'h1234;
    tick();
    exm_reg_write_i = 1'b0; mwb_reg_write_i = 1'b1; mwb_dst_i = 5'd10; mwb_result_i = 32'h1234;
    tick();
    mwb_reg_write_i = 1'b0;
    tick();
    stall_i = 1'b0;
    #1;
    chk("stall_in1", in1_o, 32'h1234);
    chk("stall_pc", ex_pc_o, 32'h200);
    chk("stall_dst", {27'b0, ex_dst_o}, 32'd11);
    tick();
    chk("post_stall_pc", ex_pc_o, 32'h204);
    // flush beats stall
    stall_i = 1'b1; flush_i = 1'b1;
    tick();
    chk("flush_valid", {31'b0, ex_valid_o}, 32'd0);
    chk("flush_regwr", {31'b0, ex_reg_write_o}, 32'd0);
    chk("flush_in2", in2_o, 32'h0);
    idle();
    // async reset mid-stall with a load-use hazard pending
    instr(5'd1, 5'd2, 32'h3, 32'h4, ALU_ADD, 5'd7);
    id_mem_read_i = 1'b1;
    tick();
    instr(5'd7, 5'd2, 32'h0, 32'h0, ALU_ADD, 5'd9);
    stall_i = 1'b1;
    #1;
    chk("pre_rst_lus", {31'b0, load_use_stall_o}, 32'd1);
    chk("pre_rst_in1", in1_o, 32'h3);
    #1 reset_i = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, ex_valid_o}, 32'd0);
    chk("async_rst_in1", in1_o, 32'h0);
    chk("async_rst_in2", in2_o, 32'h0);
    chk("async_rst_lus", {31'b0, load_use_stall_o}, 32'd0);
    tick();
    reset_i = 1'b0;
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
